// File: rtl/get_timestamp_if.sv
// get_timestamp_if: stream and timestamp handshake bundle for get_timestamp.
//   s_axis_*  : incoming [frame][timestamp] stream (tlast on last timestamp beat)
//   m_axis_*  : outgoing frame-only stream (tlast on last frame beat)
//   m_ts_*    : extracted per-frame timestamp, valid/ready
// Modports: slave = the get_timestamp block side, master = the environment side.
interface get_timestamp_if #(
  parameter int DATA_WIDTH      = 8,
  parameter int TIMESTAMP_WIDTH = 72
);
  logic [DATA_WIDTH-1:0]      s_axis_tdata;
  logic                       s_axis_tvalid;
  logic                       s_axis_tready;
  logic                       s_axis_tlast;
  logic [DATA_WIDTH-1:0]      m_axis_tdata;
  logic                       m_axis_tvalid;
  logic                       m_axis_tready;
  logic                       m_axis_tlast;
  logic [TIMESTAMP_WIDTH-1:0] m_ts_tdata;
  logic                       m_ts_tvalid;
  logic                       m_ts_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, m_ts_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_ts_tdata, m_ts_tvalid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, m_ts_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_ts_tdata, m_ts_tvalid
  );
endinterface

// File: rtl/get_timestamp.sv
// get_timestamp: strips the trailing N = TIMESTAMP_WIDTH/DATA_WIDTH timestamp
// beats off a [frame][timestamp] stream, re-marks tlast on the last frame beat
// and presents the timestamp on its own valid/ready port.
// Ports:
//   clk, rstn     : clock, synchronous active-low reset
//   axis (slave)  : s_axis_* in, m_axis_* frame out, m_ts_* timestamp out
//   err_runt_cnt  : 16-bit saturating runt-drop count, present only when
//                   GET_TIMESTAMP_ERR_CNT_EN is defined
// An N-deep delay line holds the most recent beats; once full, every input
// beat pushes the oldest one out, so the last N beats (the timestamp) never
// reach the frame output.
module get_timestamp #(
  parameter int DATA_WIDTH      = 8,
  parameter int TIMESTAMP_WIDTH = 72
) (
  input  logic clk,
  input  logic rstn,
  get_timestamp_if.slave axis
`ifdef GET_TIMESTAMP_ERR_CNT_EN
  ,
  output logic [15:0] err_runt_cnt
`endif
);
  localparam int N  = TIMESTAMP_WIDTH / DATA_WIDTH;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);

  logic [N-1:0][DATA_WIDTH-1:0] dly;   // dly[0] is the oldest beat
  logic [CW-1:0]                cnt;
  logic                         ts_valid;
  logic [TIMESTAMP_WIDTH-1:0]   ts_q;
  logic                         full;
  logic                         acc;

  assign full = (cnt == CNT_FULL);

  // Input is frozen while a timestamp is waiting, keeping frames and
  // timestamps paired one to one.
  assign axis.s_axis_tready = rstn & ~ts_valid & (~full | axis.m_axis_tready);
  assign axis.m_axis_tvalid = axis.s_axis_tvalid & ~ts_valid & full;
  assign axis.m_axis_tdata  = dly[0];
  assign axis.m_axis_tlast  = axis.s_axis_tlast;
  assign axis.m_ts_tdata    = ts_q;
  assign axis.m_ts_tvalid   = ts_valid;

  assign acc = axis.s_axis_tvalid & axis.s_axis_tready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      dly      <= '0;
      cnt      <= '0;
      ts_valid <= 1'b0;
      ts_q     <= '0;
`ifdef GET_TIMESTAMP_ERR_CNT_EN
      err_runt_cnt <= '0;
`endif
    end else begin
      if (ts_valid && axis.m_ts_tready)
        ts_valid <= 1'b0;
      // acc implies !ts_valid, so the clear above never collides with a set.
      if (acc) begin
        if (!full) begin
          if (axis.s_axis_tlast) begin
            // Runt: N or fewer beats total, no frame byte. Drop silently.
            cnt <= '0;
`ifdef GET_TIMESTAMP_ERR_CNT_EN
            if (err_runt_cnt != 16'hFFFF)
              err_runt_cnt <= err_runt_cnt + 16'd1;
`endif
          end else begin
            for (int i = 0; i < N; i++)
              if (cnt == CW'(i)) dly[i] <= axis.s_axis_tdata;
            cnt <= cnt + 1'b1;
          end
        end else if (!axis.s_axis_tlast) begin
          for (int i = 0; i < N - 1; i++)
            dly[i] <= dly[i+1];
          dly[N-1] <= axis.s_axis_tdata;
        end else begin
          // Frame end: dly[1..N-1] plus the current beat are the timestamp,
          // beat 0 in the LSBs.
          for (int i = 0; i < N - 1; i++)
            ts_q[i*DATA_WIDTH +: DATA_WIDTH] <= dly[i+1];
          ts_q[(N-1)*DATA_WIDTH +: DATA_WIDTH] <= axis.s_axis_tdata;
          ts_valid <= 1'b1;
          cnt      <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_get_timestamp.sv
// tb_get_timestamp: randomized scoreboard bench for get_timestamp.
// Frames are issued as [bytes][N timestamp beats]; the expected frame beats
// and timestamp are queued at issue time and a negedge monitor pops and
// compares on every output handshake.
module tb_get_timestamp;
  localparam int DW  = 8;
  localparam int TSW = 72;
  localparam int N   = TSW / DW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  get_timestamp_if #(.DATA_WIDTH(DW), .TIMESTAMP_WIDTH(TSW)) bus();
`ifdef GET_TIMESTAMP_ERR_CNT_EN
  logic [15:0] err_runt_cnt;
`endif

  get_timestamp #(.DATA_WIDTH(DW), .TIMESTAMP_WIDTH(TSW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .axis (bus.slave)
`ifdef GET_TIMESTAMP_ERR_CNT_EN
    ,
    .err_runt_cnt (err_runt_cnt)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t          exp_beats[$];
  logic [TSW-1:0] exp_ts[$];
  int checks = 0;
  int failures = 0;
  int exp_runt = 0;
  int cyc = 0;
  int last_cyc = -10;
  logic prev_tsv = 1'b0;
  int m_mode = 0;   // 0: ready=1, 1: toggle, 2: random
  int ts_mode = 0;  // 0: ready=1, 1: random, 2: held low
  bit gaps = 1'b0;
  beat_t e;
  logic [TSW-1:0] et;

  task automatic chk(input string name, input logic [TSW-1:0] act, input logic [TSW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready generators
  initial begin
    bus.m_axis_tready = 1'b1;
    bus.m_ts_tready   = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (m_mode)
        0:       bus.m_axis_tready = 1'b1;
        1:       bus.m_axis_tready = ~bus.m_axis_tready;
        default: bus.m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      case (ts_mode)
        0:       bus.m_ts_tready = 1'b1;
        1:       bus.m_ts_tready = 1'($urandom_range(0, 1));
        default: bus.m_ts_tready = 1'b0;
      endcase
    end
  end

  // Monitor: handshake decided at negedge completes at the next posedge
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.m_axis_tvalid)
        chk("s_ready_mirrors_m_ready", TSW'(bus.s_axis_tready), TSW'(bus.m_axis_tready));
      if (bus.m_ts_tvalid)
        chk("s_ready_blocked_by_ts", TSW'(bus.s_axis_tready), '0);
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (exp_beats.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat: got data %0h last %0b, expected none",
                   bus.m_axis_tdata, bus.m_axis_tlast);
        end else begin
          e = exp_beats.pop_front();
          chk("beat_data", TSW'(bus.m_axis_tdata), TSW'(e.d));
          chk("beat_last", TSW'(bus.m_axis_tlast), TSW'(e.l));
          if (bus.m_axis_tlast) last_cyc = cyc;
        end
      end
      if (bus.m_ts_tvalid && !prev_tsv)
        chk("ts_latency", TSW'(cyc), TSW'(last_cyc + 1));
      if (bus.m_ts_tvalid && bus.m_ts_tready) begin
        if (exp_ts.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ts: got %0h, expected none", bus.m_ts_tdata);
        end else begin
          et = exp_ts.pop_front();
          chk("ts_data", bus.m_ts_tdata, et);
        end
      end
      prev_tsv = bus.m_ts_tvalid;
    end else begin
      prev_tsv = 1'b0;
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int t = 0;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = l;
    bus.s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!bus.s_axis_tready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!bus.s_axis_tready) begin
      checks++; failures++;
      $display("FAIL send_timeout: s_axis_tready 0, required 1 within 2000 cycles");
    end
    @(posedge clk); #1;
    bus.s_axis_tvalid = 1'b0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] bytes[$], input logic [TSW-1:0] ts);
    beat_t b;
    for (int i = 0; i < bytes.size(); i++) begin
      b.d = bytes[i];
      b.l = (i == bytes.size() - 1);
      exp_beats.push_back(b);
    end
    exp_ts.push_back(ts);
    for (int i = 0; i < bytes.size(); i++) send_beat(bytes[i], 1'b0);
    for (int i = 0; i < N; i++) send_beat(ts[i*DW +: DW], 1'b1 ? (i == N - 1) : 1'b0);
  endtask

  task automatic send_runt(input int k);
    exp_runt++;
    for (int i = 0; i < k; i++) send_beat(DW'($urandom), i == k - 1);
  endtask

  task automatic rand_frame(input int len);
    logic [DW-1:0] q[$];
    logic [TSW-1:0] ts;
    for (int i = 0; i < len; i++) q.push_back(DW'($urandom));
    ts = {$urandom, $urandom, $urandom};
    send_frame(q, ts);
  endtask

  initial begin
    logic [DW-1:0] q[$];
    int t;
    beat_t b;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", TSW'(bus.s_axis_tready), '0);
    chk("rst_m_valid", TSW'(bus.m_axis_tvalid), '0);
    chk("rst_ts_valid", TSW'(bus.m_ts_tvalid), '0);
    chk("rst_ts_data", bus.m_ts_tdata, '0);
`ifdef GET_TIMESTAMP_ERR_CNT_EN
    chk("rst_err_cnt", TSW'(err_runt_cnt), '0);
`endif
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("idle_s_ready", TSW'(bus.s_axis_tready), TSW'(1));

    // 64-byte frame, all ready
    q = {};
    for (int i = 0; i < 64; i++) q.push_back(DW'(i));
    send_frame(q, 72'h0807060504030201AB);

    // Same frame with toggling frame ready
    m_mode = 1;
    send_frame(q, 72'h0807060504030201AB);
    m_mode = 0;

    // Timestamp held off while a second frame is pending
    ts_mode = 2;
    rand_frame(30);
    bus.s_axis_tdata  = 8'hC3;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("held_ts_blocks_input", TSW'(bus.s_axis_tready), '0);
    end
    ts_mode = 0;
    q = {};
    for (int i = 0; i < 40; i++) q.push_back(DW'(8'hC3 + i));
    send_frame(q, 72'hA1B2C3D4E5F6071829);

    // Runt then normal frame
    send_runt(5);
    repeat (4) @(posedge clk);
    #1;
`ifdef GET_TIMESTAMP_ERR_CNT_EN
    chk("err_cnt_after_runt", TSW'(err_runt_cnt), TSW'(exp_runt));
`endif
    rand_frame(17);

    // Single-byte frame
    q = {};
    q.push_back(8'h5A);
    send_frame(q, 72'h1122334455667788_99);

    // Reset after 20 beats of a frame
    t = 0;
    while ((exp_beats.size() != 0 || exp_ts.size() != 0) && t < 2000) begin
      @(posedge clk); t++;
    end
    #1;
    for (int i = 0; i < 20 - N; i++) begin
      b.d = DW'(8'h80 + i);
      b.l = 1'b0;
      exp_beats.push_back(b);
    end
    for (int i = 0; i < 20; i++) send_beat(DW'(8'h80 + i), 1'b0);
    rstn = 1'b0;
    chk("partial_beats_emitted", TSW'(exp_beats.size()), '0);
    exp_beats = {};
    @(posedge clk);
    @(negedge clk);
    chk("midrst_s_ready", TSW'(bus.s_axis_tready), '0);
    chk("midrst_m_valid", TSW'(bus.m_axis_tvalid), '0);
    chk("midrst_ts_valid", TSW'(bus.m_ts_tvalid), '0);
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_runt = 0;
    q = {};
    for (int i = 0; i < 64; i++) q.push_back(DW'(i * 3));
    send_frame(q, 72'hFEDCBA987654321000);

    // Randomized traffic
    for (int k = 0; k < 25; k++) begin
      m_mode  = $urandom_range(0, 2);
      ts_mode = $urandom_range(0, 1);
      gaps    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) send_runt($urandom_range(1, N));
      else rand_frame($urandom_range(1, 80));
    end
    m_mode = 0;
    ts_mode = 0;
    gaps = 1'b0;

    // Drain
    t = 0;
    while ((exp_beats.size() != 0 || exp_ts.size() != 0) && t < 5000) begin
      @(posedge clk); t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_beats", TSW'(exp_beats.size()), '0);
    chk("drain_ts", TSW'(exp_ts.size()), '0);
`ifdef GET_TIMESTAMP_ERR_CNT_EN
    chk("err_cnt_final", TSW'(err_runt_cnt), TSW'(exp_runt));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
